tennis_responder: RTL and testbench



---
 rtl/tennis_pkg.sv | 29 ++
 rtl/tennis_if.sv | 24 ++
 rtl/tennis_watchdog.sv | 45 ++++
 rtl/tennis_responder.sv | 168 ++++++++++++++++
 tb/tb_tennis_responder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tennis_pkg.sv
// Shared types and constants for the tennis responder.
package tennis_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      LISTEN  = 2'd0,
      ACK     = 2'd1,
      REPLY   = 2'd2,
      TX_BUSY = 2'd3
   } resp_state_t;

   localparam int CNT_W_DEF = 8;

   // Last TX_BUSY cycle index (0-based) before a launch is assumed even if
   // the Encoder never dropped avail: start pulse plus four busy cycles.
   localparam logic [1:0] TX_GRACE_LAST = 2'd3;

   // Worst-case rally round trip: symbol slots per packet times slot length,
   // plus decoder history flush.
   function automatic int tennis_timeout(input int n_mod, input int l,
                                         input int pre_ct, input int n_pkt,
                                         input int hist);
      return ((2 ** n_mod) * l) * (pre_ct + n_pkt / n_mod) + 5 * hist;
   endfunction

   // Link settings: N_MOD=2, L=10, PRE_CT=34, N_PKT=8, HISTORY_SIZE=4.
   localparam int TIMEOUT_DEF = tennis_timeout(2, 10, 34, 8, 4);

endpackage

// File: rtl/tennis_if.sv
// Decoder/Encoder handshake bundle seen by the responder.
interface tennis_if #(
   parameter int N_PKT = 8
);
   logic [N_PKT-1:0] data_DEC;
   logic             avail_DEC;
   logic             error_DEC;
   logic             read_DEC;
   logic             avail_ENC;
   logic             start_ENC;
   logic [N_PKT-1:0] data_ENC;

   // Responder side.
   modport slave (
      input  data_DEC, avail_DEC, error_DEC, avail_ENC,
      output read_DEC, start_ENC, data_ENC
   );

   // Link side (Decoder + Encoder).
   modport master (
      output data_DEC, avail_DEC, error_DEC, avail_ENC,
      input  read_DEC, start_ENC, data_ENC
   );
endinterface

// File: rtl/tennis_watchdog.sv
// Rally watchdog: counts enabled cycles once armed, flags the terminal count.
module tennis_watchdog #(
   parameter int TIMEOUT = 1540
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic arm,
   input  logic en,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] TC = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         armed_q, armed_d;

   // Clear has priority over counting; arming is sticky until reset.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en && armed_q) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (arm) begin
         armed_d = 1'b1;
      end
   end

   // Counter and arm flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign expire = armed_q && en && (cnt_q == TC);

endmodule

// File: rtl/tennis_responder.sv
// Responder end of the PPM tennis rally: checks serves, launches returns,
// keeps rally/error statistics and retransmits on watchdog expiry.
//
// state   | meaning
// --------+-------------------------------------------------------------
// LISTEN  | waiting for a Decoder packet; watchdog runs once armed
// ACK     | read_DEC pulse; judge captured packet, update statistics
// REPLY   | data_ENC valid; launch start_ENC when the Encoder is idle
// TX_BUSY | Encoder transmitting; wait for busy then idle
module tennis_responder
   import tennis_pkg::*;
#(
   parameter int N_PKT   = 8,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_PKT-1:0] data2send,
   input  logic [N_PKT-1:0] data_expected,
   tennis_if.slave          link,
   output logic             expected_data_received,
   output logic [CNT_W-1:0] rally_count,
   output logic [CNT_W-1:0] err_count,
   output logic             timeout_pulse
);

   resp_state_t      state_q, state_d;
   logic [N_PKT-1:0] cap_data_q, cap_data_d;
   logic             cap_err_q, cap_err_d;
   logic [N_PKT-1:0] data_enc_q, data_enc_d;
   logic             read_dec_q, read_dec_d;
   logic             start_enc_q, start_enc_d;
   logic             timeout_q, timeout_d;
   logic             edr_q, edr_d;
   logic [CNT_W-1:0] rally_q, rally_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             seen_low_q, seen_low_d;
   logic [1:0]       busy_cnt_q, busy_cnt_d;
   logic             wd_clear, wd_arm, wd_en, wd_expire;

   tennis_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .arm    (wd_arm),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // Next-state and registered-output decode. Pulses are computed one cycle
   // ahead so that start_ENC can rise in the first REPLY cycle.
   always_comb begin
      state_d     = state_q;
      cap_data_d  = cap_data_q;
      cap_err_d   = cap_err_q;
      data_enc_d  = data_enc_q;
      read_dec_d  = 1'b0;
      start_enc_d = 1'b0;
      timeout_d   = 1'b0;
      edr_d       = edr_q;
      rally_d     = rally_q;
      err_d       = err_q;
      seen_low_d  = seen_low_q;
      busy_cnt_d  = busy_cnt_q;
      wd_clear    = 1'b0;
      wd_arm      = 1'b0;
      wd_en       = 1'b0;

      case (state_q)
         LISTEN: begin
            // A pending serve masks expiry on the same cycle.
            wd_en = !link.avail_DEC;
            if (link.avail_DEC) begin
               cap_data_d = link.data_DEC;
               cap_err_d  = link.error_DEC;
               read_dec_d = 1'b1;
               wd_clear   = 1'b1;
               state_d    = ACK;
            end else if (wd_expire) begin
               timeout_d   = 1'b1;
               wd_clear    = 1'b1;
               start_enc_d = link.avail_ENC;
               state_d     = REPLY;
            end
         end

         ACK: begin
            if (cap_err_q || (cap_data_q != data_expected)) begin
               if (err_q != '1) begin
                  err_d = err_q + 1'b1;
               end
               state_d = LISTEN;
            end else begin
               rally_d     = rally_q + 1'b1;
               edr_d       = 1'b1;
               data_enc_d  = data2send;
               start_enc_d = link.avail_ENC;
               state_d     = REPLY;
            end
         end

         REPLY: begin
            seen_low_d = 1'b0;
            busy_cnt_d = '0;
            if (start_enc_q) begin
               state_d = TX_BUSY;
            end else if (link.avail_ENC) begin
               start_enc_d = 1'b1;
            end
         end

         TX_BUSY: begin
            seen_low_d = seen_low_q | !link.avail_ENC;
            if (busy_cnt_q != TX_GRACE_LAST) begin
               busy_cnt_d = busy_cnt_q + 1'b1;
            end
            if (link.avail_ENC && (seen_low_q || (busy_cnt_q == TX_GRACE_LAST))) begin
               wd_clear = 1'b1;
               wd_arm   = 1'b1;
               state_d  = LISTEN;
            end
         end

         default: state_d = LISTEN;
      endcase
   end

   // State and output registers; reset drops every output immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LISTEN;
         cap_data_q  <= '0;
         cap_err_q   <= 1'b0;
         data_enc_q  <= '0;
         read_dec_q  <= 1'b0;
         start_enc_q <= 1'b0;
         timeout_q   <= 1'b0;
         edr_q       <= 1'b0;
         rally_q     <= '0;
         err_q       <= '0;
         seen_low_q  <= 1'b0;
         busy_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cap_data_q  <= cap_data_d;
         cap_err_q   <= cap_err_d;
         data_enc_q  <= data_enc_d;
         read_dec_q  <= read_dec_d;
         start_enc_q <= start_enc_d;
         timeout_q   <= timeout_d;
         edr_q       <= edr_d;
         rally_q     <= rally_d;
         err_q       <= err_d;
         seen_low_q  <= seen_low_d;
         busy_cnt_q  <= busy_cnt_d;
      end
   end

   assign link.read_DEC          = read_dec_q;
   assign link.start_ENC         = start_enc_q;
   assign link.data_ENC          = data_enc_q;
   assign expected_data_received = edr_q;
   assign rally_count            = rally_q;
   assign err_count              = err_q;
   assign timeout_pulse          = timeout_q;

endmodule

// File: tb/tb_tennis_responder.sv
// Bench for tennis_responder: vector table, randomized serves against an
// event-level model, and hand sequences for watchdog, race, busy and reset.
module tb_tennis_responder;
   localparam int TMO = 1540;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data2send = '0;
   logic [7:0] data_expected = '0;
   logic       edr;
   logic [7:0] rally;
   logic [7:0] errc;
   logic       tmo;

   tennis_if #(.N_PKT(8)) link();

   tennis_responder #(.N_PKT(8), .TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .data2send              (data2send),
      .data_expected          (data_expected),
      .link                   (link),
      .expected_data_received (edr),
      .rally_count            (rally),
      .err_count              (errc),
      .timeout_pulse          (tmo)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   int n_read = 0, n_start = 0, n_tmo = 0, dbl = 0;
   int start_cyc = 0, tmo_cyc = 0, rise_cyc = 0;
   logic [7:0] start_data = '0;
   int  enc_lat = 2;
   bit  enc_force_busy = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Pulse monitor.
   initial begin
      bit pr, ps, pt;
      pr = 0; ps = 0; pt = 0;
      forever begin
         @(negedge clk);
         if (link.read_DEC === 1'b1) n_read++;
         if (link.start_ENC === 1'b1) begin
            n_start++;
            start_data = link.data_ENC;
            start_cyc  = cyc;
         end
         if (tmo === 1'b1) begin
            n_tmo++;
            tmo_cyc = cyc;
         end
         if ((pr && link.read_DEC) || (ps && link.start_ENC) || (pt && tmo)) dbl++;
         pr = link.read_DEC; ps = link.start_ENC; pt = tmo;
      end
   end

   // Encoder model: goes busy the cycle after it sees start, for enc_lat
   // cycles (0 = never visibly busy).
   initial begin
      bit pend, prev;
      int left;
      pend = 0; left = 0;
      link.avail_ENC = 1'b1;
      forever begin
         @(negedge clk);
         prev = link.avail_ENC;
         if (enc_force_busy) begin
            link.avail_ENC = 1'b0;
         end else if (pend) begin
            pend = 0;
            if (enc_lat > 0) begin
               link.avail_ENC = 1'b0;
               left = enc_lat;
            end
         end else if (left > 0) begin
            left--;
            if (left == 0) link.avail_ENC = 1'b1;
         end else begin
            link.avail_ENC = 1'b1;
         end
         if (!prev && link.avail_ENC) rise_cyc = cyc;
         if (link.start_ENC === 1'b1) pend = 1;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic serve(input logic [7:0] d, input bit e);
      int r0;
      r0 = n_read;
      step();
      link.data_DEC  = d;
      link.error_DEC = e;
      link.avail_DEC = 1'b1;
      step();
      chk("read_latency", link.read_DEC, 1);
      link.avail_DEC = 1'b0;
      repeat (14) step();
      chk("read_once", n_read - r0, 1);
   endtask

   task automatic wait_start(input int s0, input int budget, input string nm);
      int k;
      k = 0;
      while (n_start == s0 && k < budget) begin
         step();
         k++;
      end
      chk(nm, n_start > s0, 1);
   endtask

   typedef struct {
      logic [7:0] d;
      logic [7:0] expd;
      logic [7:0] send;
      logic       err;
      logic       reply;
      logic [7:0] enc;
      logic [7:0] rally;
      logic [7:0] errc;
      logic       edr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [7:0] ref_rally, ref_err, ref_enc;
      logic       ref_edr;
      logic [7:0] d, ex, sd;
      bit         e, m, exp_st;
      int         s0, t0, rc;

      link.data_DEC  = '0;
      link.avail_DEC = 1'b0;
      link.error_DEC = 1'b0;

      tbl[0] = '{8'h42, 8'h42, 8'h8f, 1'b0, 1'b1, 8'h8f, 8'd1, 8'd0, 1'b1};
      tbl[1] = '{8'h42, 8'h42, 8'h11, 1'b1, 1'b0, 8'h8f, 8'd1, 8'd1, 1'b1};
      tbl[2] = '{8'h13, 8'h14, 8'h22, 1'b0, 1'b0, 8'h8f, 8'd1, 8'd2, 1'b1};
      tbl[3] = '{8'ha5, 8'ha5, 8'h3c, 1'b0, 1'b1, 8'h3c, 8'd2, 8'd2, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 8'hff, 1'b1, 1'b0, 8'h3c, 8'd2, 8'd3, 1'b1};
      tbl[5] = '{8'hff, 8'hff, 8'h01, 1'b0, 1'b1, 8'h01, 8'd3, 8'd3, 1'b1};

      // Reset state.
      #1 rst = 1'b1;
      #1;
      chk("rst_read", link.read_DEC, 0);
      chk("rst_start", link.start_ENC, 0);
      chk("rst_data_enc", link.data_ENC, 0);
      chk("rst_edr", edr, 0);
      chk("rst_rally", rally, 0);
      chk("rst_err", errc, 0);
      chk("rst_tmo", tmo, 0);
      repeat (3) step();
      rst = 1'b0;

      // Never served: watchdog must stay quiet.
      repeat (TMO + 60) step();
      chk("idle_no_timeout", n_tmo, 0);
      chk("idle_no_start", n_start, 0);

      // Vector table.
      for (int i = 0; i < 6; i++) begin
         s0 = n_start;
         data_expected = tbl[i].expd;
         data2send     = tbl[i].send;
         serve(tbl[i].d, tbl[i].err);
         chk($sformatf("v%0d_starts", i), n_start - s0, 32'(tbl[i].reply));
         if (tbl[i].reply) chk($sformatf("v%0d_start_data", i), start_data, tbl[i].enc);
         chk($sformatf("v%0d_data_enc", i), link.data_ENC, tbl[i].enc);
         chk($sformatf("v%0d_rally", i), rally, tbl[i].rally);
         chk($sformatf("v%0d_err", i), errc, tbl[i].errc);
         chk($sformatf("v%0d_edr", i), edr, tbl[i].edr);
      end

      // Randomized serves against an event-level model.
      ref_rally = 8'd3; ref_err = 8'd3; ref_enc = 8'h01; ref_edr = 1'b1;
      for (int k = 0; k < 40; k++) begin
         d  = 8'($urandom);
         m  = ($urandom_range(0, 1) == 1);
         e  = ($urandom_range(0, 3) == 0);
         ex = m ? d : (d ^ 8'(32'd1 << $urandom_range(0, 7)));
         sd = 8'($urandom);
         enc_lat = $urandom_range(0, 5);
         data_expected = ex;
         data2send     = sd;
         s0 = n_start;
         serve(d, e);
         if (!e && d == ex) begin
            ref_rally = ref_rally + 8'd1;
            ref_edr   = 1'b1;
            ref_enc   = sd;
            exp_st    = 1;
         end else begin
            if (ref_err != 8'hff) ref_err = ref_err + 8'd1;
            exp_st = 0;
         end
         chk($sformatf("r%0d_starts", k), n_start - s0, 32'(exp_st));
         if (exp_st) chk($sformatf("r%0d_start_data", k), start_data, ref_enc);
         chk($sformatf("r%0d_data_enc", k), link.data_ENC, ref_enc);
         chk($sformatf("r%0d_rally", k), rally, ref_rally);
         chk($sformatf("r%0d_err", k), errc, ref_err);
      end

      // Error counter saturation.
      enc_lat = 2;
      data_expected = 8'h42;
      repeat (260) begin
         serve(8'h42, 1'b1);
         if (ref_err != 8'hff) ref_err = ref_err + 8'd1;
      end
      chk("err_saturate_model", errc, ref_err);
      chk("err_saturate_max", errc, 8'hff);
      chk("err_saturate_rally", rally, ref_rally);

      // Timeout retransmit.
      data2send = 8'h8f;
      s0 = n_start;
      t0 = n_tmo;
      serve(8'h42, 1'b0);
      ref_rally = ref_rally + 8'd1;
      rc = rise_cyc;
      for (int k = 0; k < TMO + 100 && n_tmo == t0; k++) step();
      chk("tmo_seen", n_tmo - t0, 1);
      chk("tmo_cycle", tmo_cyc - rc, TMO + 1);
      wait_start(s0 + 1, 10, "tmo_retx_seen");
      chk("tmo_retx_data", start_data, 8'h8f);
      chk("tmo_rally_unchanged", rally, ref_rally);
      repeat (12) step();
      chk("tmo_starts", n_start - s0, 2);

      // Serve arriving on the exact expiry cycle.
      rc = rise_cyc;
      t0 = n_tmo;
      s0 = n_start;
      data2send = 8'h5a;
      while (cyc < rc + TMO - 1) step();
      serve(8'h42, 1'b0);
      ref_rally = ref_rally + 8'd1;
      chk("race_no_timeout", n_tmo - t0, 0);
      chk("race_starts", n_start - s0, 1);
      chk("race_data", start_data, 8'h5a);
      chk("race_rally", rally, ref_rally);

      // Busy Encoder holds off the launch.
      enc_force_busy = 1'b1;
      s0 = n_start;
      data2send = 8'hc3;
      serve(8'h42, 1'b0);
      repeat (186) step();
      chk("busy_withheld", n_start - s0, 0);
      enc_force_busy = 1'b0;
      wait_start(s0, 10, "busy_start_seen");
      chk("busy_start_timing", start_cyc - rise_cyc, 1);
      repeat (12) step();
      chk("busy_single_start", n_start - s0, 1);
      chk("busy_data", start_data, 8'hc3);

      // Reset in TX_BUSY.
      enc_lat = 5;
      data2send = 8'h99;
      s0 = n_start;
      step();
      link.data_DEC = 8'h42; link.error_DEC = 1'b0; link.avail_DEC = 1'b1;
      step();
      link.avail_DEC = 1'b0;
      wait_start(s0, 10, "rst_pre_start");
      step();
      step();
      rst = 1'b1;
      #1;
      chk("mid_rst_start", link.start_ENC, 0);
      chk("mid_rst_read", link.read_DEC, 0);
      chk("mid_rst_data_enc", link.data_ENC, 0);
      chk("mid_rst_rally", rally, 0);
      chk("mid_rst_err", errc, 0);
      chk("mid_rst_edr", edr, 0);
      chk("mid_rst_tmo", tmo, 0);
      repeat (3) step();
      rst = 1'b0;
      repeat (10) step();

      // Reset while read_DEC is high drops it at once.
      link.data_DEC = 8'h42; link.avail_DEC = 1'b1;
      step();
      chk("pre_rst_read_high", link.read_DEC, 1);
      rst = 1'b1;
      #1;
      chk("async_read_drop", link.read_DEC, 0);
      link.avail_DEC = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();

      // Fresh rally after reset.
      enc_lat = 2;
      data2send = 8'h77;
      s0 = n_start;
      serve(8'h42, 1'b0);
      chk("post_rst_starts", n_start - s0, 1);
      chk("post_rst_data", start_data, 8'h77);
      chk("post_rst_rally", rally, 1);
      chk("post_rst_err", errc, 0);
      chk("post_rst_edr", edr, 1);

      chk("single_cycle_pulses", dbl, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
